// File: rtl/dm_dump_arbiter.sv
// rtl/dm_dump_arbiter.sv - data-memory port arbiter between the processor and a whole-memory dump engine
module dm_dump_arbiter #(
  parameter int N  = 64,
  parameter int AW = 6
) (
  input  logic         CLOCK_50,
  input  logic         reset,
  input  logic         dump,
  input  logic [N-1:0] cpu_addr,
  input  logic [N-1:0] cpu_writeData,
  input  logic         cpu_writeEnable,
  input  logic         cpu_readEnable,
  output logic [N-1:0] cpu_readData,
  output logic         cpu_stall,
  output logic [N-1:0] DM_addr,
  output logic [N-1:0] DM_writeData,
  output logic         DM_writeEnable,
  output logic         DM_readEnable,
  input  logic [N-1:0] DM_readData,
  output logic         dump_valid,
  input  logic         dump_ready,
  output logic [N-1:0] dump_addr,
  output logic [N-1:0] dump_data,
  output logic         dump_last,
  output logic         dump_busy,
  output logic         dump_done
);

  localparam logic [AW-1:0] LAST_IDX = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_CAPTURE,
    S_HOLD,
    S_DONE
  } state_t;

  state_t         state;
  logic [AW-1:0]  idx;
  logic           dump_q;
  logic           busy_q;
  logic           valid_q;
  logic           last_q;
  logic           done_q;
  logic           start;
  logic [N-1:0]   idx_addr;

  assign start    = dump & ~dump_q;
  assign idx_addr = {{(N-AW-3){1'b0}}, idx, 3'b000};

  // Status flags are registered alongside the state so no output depends on dump_ready.
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      idx       <= '0;
      dump_q    <= 1'b0;
      dump_data <= '0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      dump_q <= dump;
      case (state)
        S_IDLE: begin
          if (start) begin
            idx    <= '0;
            busy_q <= 1'b1;
            state  <= S_READ;
          end
        end
        S_READ: begin
          state <= S_CAPTURE;
        end
        S_CAPTURE: begin
          dump_data <= DM_readData;
          valid_q   <= 1'b1;
          last_q    <= (idx == LAST_IDX);
          state     <= S_HOLD;
        end
        S_HOLD: begin
          if (dump_ready) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            if (idx == LAST_IDX) begin
              done_q <= 1'b1;
              state  <= S_DONE;
            end else begin
              idx   <= idx + 1'b1;
              state <= S_READ;
            end
          end
        end
        S_DONE: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          state  <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Outside IDLE the processor strobes are dropped so a stalled store never reaches memory.
  always_comb begin
    DM_addr        = cpu_addr;
    DM_writeData   = cpu_writeData;
    DM_writeEnable = cpu_writeEnable;
    DM_readEnable  = cpu_readEnable;
    if (state != S_IDLE) begin
      DM_addr        = idx_addr;
      DM_writeData   = '0;
      DM_writeEnable = 1'b0;
      DM_readEnable  = (state == S_READ);
    end
  end

  assign cpu_readData = DM_readData;
  assign cpu_stall    = busy_q;
  assign dump_busy    = busy_q;
  assign dump_valid   = valid_q;
  assign dump_last    = last_q;
  assign dump_done    = done_q;
  assign dump_addr    = idx_addr;

endmodule

// File: doc/dm_dump_arbiter.md
# dm_dump_arbiter

- Owns the data-memory port and shares it between two requesters:
  - the 64-bit single-cycle processor's data-memory interface;
  - an internal dump engine that streams the whole data memory out on a valid/ready port when `dump` is raised.
- Placement: between `processor_arm`'s DM_* signals and the data memory.
- While a dump runs, the processor is stalled and the dump engine owns the memory.
- In idle, the arbiter is a transparent pass-through.

## Interface
Parameters:
- N, 64, data and address width
- AW, 6, word-index width; dump covers DEPTH = 2**AW words of 8 bytes each

Ports:
- CLOCK_50  in  1  clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-low; 0 forces reset state immediately
- dump  in  1  dump request; a 0->1 transition sampled while in IDLE starts one dump sequence
- cpu_addr  in  N  processor byte address
- cpu_writeData  in  N  processor store data
- cpu_writeEnable  in  1  processor store strobe
- cpu_readEnable  in  1  processor load strobe
- cpu_readData  out  N  load data returned to the processor
- cpu_stall  out  1  processor must hold its current access while 1
- DM_addr  out  N  memory byte address
- DM_writeData  out  N  memory write data
- DM_writeEnable  out  1  memory write strobe
- DM_readEnable  out  1  memory read strobe
- DM_readData  in  N  memory read data; synchronous RAM, valid in the cycle after DM_readEnable
- dump_valid  out  1  dump_data/dump_addr hold a valid word
- dump_ready  in  1  consumer accepts the word when dump_valid & dump_ready
- dump_addr  out  N  byte address of the current word (index*8)
- dump_data  out  N  current word
- dump_last  out  1  current word is index DEPTH-1
- dump_busy  out  1  dump sequence in progress
- dump_done  out  1  one-cycle pulse after the last word is accepted

## Operation
- Registered state: state, idx (AW bits), dump_q (registered copy of dump, updated in every state), dump_data.
- Edge detect: start = dump & ~dump_q.
- start is honoured only in IDLE. It is ignored in all other states.
- A level held high never retriggers; dump must return to 0 and rise again.

FSM states and transitions:
- IDLE:
  - DM_* = cpu_* combinationally.
  - On start: idx <= 0, go to READ. The CPU access in the start cycle still completes.
- READ: DM_readEnable=1, DM_writeEnable=0, DM_addr={idx,3'b000} zero-extended to N, DM_writeData=0. Go to CAPTURE.
- CAPTURE:
  - DM_readData is valid this cycle; dump_data <= DM_readData.
  - All DM strobes 0. Go to HOLD.
- HOLD:
  - dump_valid=1; dump_addr={idx,3'b000}; dump_last=(idx==DEPTH-1). All DM strobes 0.
  - If dump_ready and idx==DEPTH-1: go to DONE.
  - If dump_ready otherwise: idx <= idx+1 and go to READ.
  - If not dump_ready: stay in HOLD with dump_addr/dump_data stable.
- DONE: dump_done=1, DM strobes 0, go to IDLE.

Signal rules:
- cpu_stall = dump_busy = (state != IDLE).
- In non-IDLE states, cpu_writeEnable and cpu_readEnable are never forwarded, so a stalled store cannot corrupt memory.
- cpu_readData = DM_readData in all states. The processor ignores it while cpu_stall=1.
- idx never wraps: exit happens at DEPTH-1.

Reset:
- Reset asserted mid-dump aborts at once: state IDLE, idx 0, dump_q 0, dump_data 0. No dump_done pulse.
- dump_q resets to 0, so dump already high on reset release counts as an edge at the first clock.

## Timing
- Reset values: cpu_stall 0, dump_busy 0, dump_valid 0, dump_last 0, dump_done 0, dump_addr 0, dump_data 0.
- During reset, DM_* and cpu_readData follow the IDLE pass-through.
- Start edge sampled at clock edge E0:
  - READ in cycle 1, CAPTURE in cycle 2, HOLD in cycle 3.
- With dump_ready tied high:
  - word k is valid in cycle 3+3k;
  - last word in cycle 3*DEPTH, DONE in 3*DEPTH+1;
  - cpu_stall falls in cycle 3*DEPTH+2.
- Each cycle of dump_ready low in HOLD adds exactly one cycle.
- All outputs except the IDLE pass-through and cpu_readData are functions of registered state only. There is no combinational dump_ready-to-output path except the state update.

## Test plan
- Idle pass-through, DEPTH=4: CPU stores 0xA5 to addr 8, then loads addr 8 → DM_* mirror cpu_*, cpu_readData=0xA5 one cycle after load, cpu_stall=0.
- Full dump, DEPTH=4, memory[i]=0x100+i, dump_ready=1:
  - dump words 0x100..0x103 at addr 0,8,16,24 in cycles 3,6,9,12;
  - dump_last only with 0x103; dump_done in cycle 13; cpu_stall low in cycle 14.
- Backpressure: dump_ready low for 5 cycles on word 1 → word 1 data/addr stable for 6 cycles, total sequence 5 cycles longer, no word skipped or duplicated.
- Stalled store: CPU holds store 0xFF to addr 0 during a dump → DM_writeEnable never 1 during the dump, dump word 0 = original value, memory[0] unchanged.
- Retrigger rules: dump held high through completion → no second sequence. dump toggled 0→1 mid-dump → ignored. Drop then raise after DONE → second full sequence.
- Reset mid-operation: reset low in HOLD of word 2 → same cycle dump_valid=0, cpu_stall=0, dump_busy=0, no dump_done. After release, the next dump edge starts from word 0.
